apb_master_q: RTL and testbench

- Parametrised, queued APB4 requester that replaces the single-shot transfer-driven master.
- Accepts commands over a valid/ready interface into a FIFO of DEPTH entries, then issues them as APB SETUP/ACCESS transfers, back-to-back where possible.
- Returns per-transfer read data and error status on a response port.
- Sits between a system-side command source (CPU bridge or DMA) and APB slaves such as the SRAM slave.

---
 rtl/apb_master_q.sv | 256 +++++++++++++++++++++++++
 tb/tb_apb_master_q.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_q.sv
// apb_master_q: queued APB4 requester.
//
// Commands arrive on a valid/ready port and are held in a DEPTH-entry FIFO.
// A three-state FSM (IDLE, SETUP, ACCESS) turns each queued command into an
// APB SETUP/ACCESS transfer. Transfers run back-to-back while the queue holds
// work. Each completed transfer produces a one-cycle response pulse carrying
// read data and error status.
//
// Optional feature: define APB_MASTER_Q_TIMEOUT_EN to add an ACCESS watchdog.
// After TIMEOUT wait cycles it aborts the transfer and reports rsp_err and
// rsp_timeout. Without the macro, rsp_timeout is tied low and ACCESS waits
// indefinitely.
//
// Ports:
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (cmd_ready = FIFO not full)
//   cmd_write/addr/wdata/strb/prot   command fields
//   rsp_valid/write/rdata/err/timeout  completion response (no backpressure)
//   busy, fifo_count       status
//   PSEL..PPROT, PRDATA, PREADY, PSLVERR   APB4 requester interface
module apb_master_q #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [ADDR_W-1:0]          cmd_addr,
    input  logic [DATA_W-1:0]          cmd_wdata,
    input  logic [DATA_W/8-1:0]        cmd_strb,
    input  logic [2:0]                 cmd_prot,
    output logic                       rsp_valid,
    output logic                       rsp_write,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       rsp_timeout,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [ADDR_W-1:0]          PADDR,
    output logic [DATA_W-1:0]          PWDATA,
    output logic [DATA_W/8-1:0]        PSTRB,
    output logic [2:0]                 PPROT,
    input  logic [DATA_W-1:0]          PRDATA,
    input  logic                       PREADY,
    input  logic                       PSLVERR
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              state_r;
    state_t              next_state_s;

    logic [ADDR_W-1:0]   addr_mem_r  [DEPTH];
    logic [DATA_W-1:0]   wdata_mem_r [DEPTH];
    logic [STRB_W-1:0]   strb_mem_r  [DEPTH];
    logic [2:0]          prot_mem_r  [DEPTH];
    logic                write_mem_r [DEPTH];

    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;

    logic                full_s;
    logic                empty_s;
    logic                push_s;
    logic                pop_s;
    logic                done_s;
    logic                abort_s;

    assign full_s     = (count_r == CNT_W'(DEPTH));
    assign empty_s    = (count_r == CNT_W'(0));
    assign cmd_ready  = !full_s;
    assign push_s     = cmd_valid && !full_s;
    assign done_s     = (state_r == ST_ACCESS) && PREADY;
    // Every entry into SETUP consumes the FIFO head.
    assign pop_s      = (next_state_s == ST_SETUP);
    assign fifo_count = count_r;
    assign busy       = (state_r != ST_IDLE) || !empty_s;

`ifdef APB_MASTER_Q_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0]   wait_cnt_r;

    // Watchdog: cleared in SETUP (the only way into ACCESS), counts stalled ACCESS cycles.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt_r <= WAIT_W'(0);
        end else if (state_r == ST_SETUP) begin
            wait_cnt_r <= WAIT_W'(0);
        end else if ((state_r == ST_ACCESS) && !PREADY) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // The limit is reached on the stalled cycle that would bring the count to TIMEOUT;
    // a PREADY on that cycle completes normally instead.
    assign abort_s = (state_r == ST_ACCESS) && !PREADY &&
                     (wait_cnt_r == WAIT_W'(TIMEOUT - 1));

    // Timeout flag accompanies each response pulse.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_timeout <= 1'b0;
        end else if (done_s) begin
            rsp_timeout <= 1'b0;
        end else if (abort_s) begin
            rsp_timeout <= 1'b1;
        end else begin
            rsp_timeout <= rsp_timeout;
        end
    end
`else
    assign abort_s     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // Command storage; contents are only meaningful between push and pop, so no reset.
    always_ff @(posedge PCLK) begin
        if (push_s) begin
            addr_mem_r[wr_ptr_r]  <= cmd_addr;
            wdata_mem_r[wr_ptr_r] <= cmd_wdata;
            strb_mem_r[wr_ptr_r]  <= cmd_strb;
            prot_mem_r[wr_ptr_r]  <= cmd_prot;
            write_mem_r[wr_ptr_r] <= cmd_write;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    next_state_s = ST_SETUP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                next_state_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (done_s || abort_s) begin
                    next_state_s = empty_s ? ST_IDLE : ST_SETUP;
                end else begin
                    next_state_s = ST_ACCESS;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // APB outputs registered from the next state; address/data load from the head on SETUP entry.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= ADDR_W'(0);
            PWDATA  <= DATA_W'(0);
            PSTRB   <= STRB_W'(0);
            PPROT   <= 3'b000;
        end else begin
            case (next_state_s)
                ST_SETUP: begin
                    PSEL    <= 1'b1;
                    PENABLE <= 1'b0;
                    PWRITE  <= write_mem_r[rd_ptr_r];
                    PADDR   <= addr_mem_r[rd_ptr_r];
                    PWDATA  <= wdata_mem_r[rd_ptr_r];
                    PSTRB   <= write_mem_r[rd_ptr_r] ? strb_mem_r[rd_ptr_r] : STRB_W'(0);
                    PPROT   <= prot_mem_r[rd_ptr_r];
                end
                ST_ACCESS: begin
                    PENABLE <= 1'b1;
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end

    // Response capture: one-cycle pulse on completion or watchdog abort; fields hold otherwise.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= DATA_W'(0);
            rsp_err   <= 1'b0;
        end else if (done_s) begin
            rsp_valid <= 1'b1;
            rsp_write <= PWRITE;
            rsp_rdata <= PWRITE ? DATA_W'(0) : PRDATA;
            rsp_err   <= PSLVERR;
        end else if (abort_s) begin
            rsp_valid <= 1'b1;
            rsp_write <= PWRITE;
            rsp_rdata <= DATA_W'(0);
            rsp_err   <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_master_q.sv
// Directed testbench for apb_master_q (default parameters). The slave side is
// a simple model: PRDATA = 0x100 | PADDR, while PREADY and PSLVERR are driven
// step by step. The watchdog test runs only when APB_MASTER_Q_TIMEOUT_EN is defined.
module tb_apb_master_q;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int checks = 0;
    int errors = 0;

    apb_master_q dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .cmd_prot    (cmd_prot),
        .rsp_valid   (rsp_valid),
        .rsp_write   (rsp_write),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PPROT       (PPROT),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    assign PRDATA = 32'h0000_0100 | PADDR;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_cnt [6];
        int exp_rdy [6];
        exp_cnt = '{1, 1, 2, 3, 4, 4};
        exp_rdy = '{1, 1, 1, 1, 0, 0};

        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_strb  = 4'h0;
        cmd_prot  = 3'b000;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_psel", PSEL, 1'b0);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_fifo_count", fifo_count, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_timeout", rsp_timeout, 1'b0);
        PRESETn = 1'b1;
        step();

        // Single write
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h10;
        cmd_wdata = 32'hDEADBEEF;
        cmd_strb  = 4'hF;
        cmd_prot  = 3'b010;
        step();
        chk("t1_count_push", fifo_count, 3'd1);
        chk("t1_psel_e0", PSEL, 1'b0);
        cmd_valid = 1'b0;
        step();
        chk("t1_setup_psel", PSEL, 1'b1);
        chk("t1_setup_penable", PENABLE, 1'b0);
        chk("t1_paddr", PADDR, 32'h10);
        chk("t1_pwrite", PWRITE, 1'b1);
        chk("t1_pwdata", PWDATA, 32'hDEADBEEF);
        chk("t1_pstrb", PSTRB, 4'hF);
        chk("t1_pprot", PPROT, 3'b010);
        chk("t1_count_pop", fifo_count, 3'd0);
        step();
        chk("t1_access_penable", PENABLE, 1'b1);
        chk("t1_access_psel", PSEL, 1'b1);
        step();
        chk("t1_rsp_valid", rsp_valid, 1'b1);
        chk("t1_rsp_err", rsp_err, 1'b0);
        chk("t1_rsp_write", rsp_write, 1'b1);
        chk("t1_rsp_rdata", rsp_rdata, 32'h0);
        chk("t1_idle_psel", PSEL, 1'b0);
        step();
        chk("t1_rsp_pulse_end", rsp_valid, 1'b0);
        chk("t1_busy_end", busy, 1'b0);

        // Four queued reads, back-to-back
        cmd_write = 1'b0;
        cmd_strb  = 4'hF;
        for (int c = 0; c < 10; c++) begin
            cmd_valid = (c < 4);
            cmd_addr  = 32'(c);
            step();
            if (c >= 1 && c <= 8) chk("t2_psel_high", PSEL, 1'b1);
            else chk("t2_psel_low", PSEL, 1'b0);
            if (c >= 1) chk("t2_pstrb_zero", PSTRB, 4'h0);
            if (c == 3 || c == 5 || c == 7 || c == 9) begin
                chk("t2_rsp_valid", rsp_valid, 1'b1);
                chk("t2_rsp_rdata", rsp_rdata, 32'h100 + 32'((c - 3) / 2));
                chk("t2_rsp_write", rsp_write, 1'b0);
                chk("t2_rsp_err", rsp_err, 1'b0);
            end else begin
                chk("t2_rsp_idle", rsp_valid, 1'b0);
            end
        end
        cmd_valid = 1'b0;

        // Wait states then slave error; following command still issues
        PREADY    = 1'b0;
        PSLVERR   = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h40;
        cmd_wdata = 32'h11;
        cmd_strb  = 4'h3;
        step();
        cmd_write = 1'b0;
        cmd_addr  = 32'h05;
        step();
        cmd_valid = 1'b0;
        step();
        chk("t3_access_entry", PENABLE, 1'b1);
        chk("t3_paddr", PADDR, 32'h40);
        for (int w = 0; w < 3; w++) begin
            step();
            chk("t3_wait_penable", PENABLE, 1'b1);
            chk("t3_wait_no_rsp", rsp_valid, 1'b0);
        end
        PREADY = 1'b1;
        step();
        chk("t3_rsp_valid", rsp_valid, 1'b1);
        chk("t3_rsp_err", rsp_err, 1'b1);
        chk("t3_rsp_write", rsp_write, 1'b1);
        chk("t3_rsp_rdata", rsp_rdata, 32'h0);
        chk("t3_rsp_timeout", rsp_timeout, 1'b0);
        chk("t3_next_psel", PSEL, 1'b1);
        chk("t3_next_penable", PENABLE, 1'b0);
        chk("t3_next_paddr", PADDR, 32'h05);
        PSLVERR = 1'b0;
        step();
        step();
        chk("t3_rd_rsp_valid", rsp_valid, 1'b1);
        chk("t3_rd_rsp_err", rsp_err, 1'b0);
        chk("t3_rd_rsp_write", rsp_write, 1'b0);
        chk("t3_rd_rsp_rdata", rsp_rdata, 32'h105);
        chk("t3_rd_psel", PSEL, 1'b0);
        step();
        chk("t3_busy_end", busy, 1'b0);

        // FIFO full while the slave stalls
        PREADY    = 1'b0;
        cmd_write = 1'b0;
        cmd_strb  = 4'h0;
        for (int c = 0; c < 6; c++) begin
            cmd_valid = 1'b1;
            cmd_addr  = 32'h80 + 32'(c);
            step();
            chk("t4_fifo_count", fifo_count, 64'(exp_cnt[c]));
            chk("t4_cmd_ready", cmd_ready, 64'(exp_rdy[c]));
        end
        cmd_valid = 1'b0;
        PREADY    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_rsp_valid", rsp_valid, 1'b1);
            chk("t4_rsp_rdata", rsp_rdata, 32'h180 + 32'(k));
            step();
            chk("t4_rsp_gap", rsp_valid, 1'b0);
        end
        chk("t4_count_end", fifo_count, 3'd0);
        chk("t4_busy_end", busy, 1'b0);

        // Reset in the middle of ACCESS with two commands queued
        PREADY    = 1'b0;
        cmd_write = 1'b1;
        cmd_strb  = 4'hF;
        for (int c = 0; c < 3; c++) begin
            cmd_valid = 1'b1;
            cmd_addr  = 32'h200 + 32'(c);
            step();
        end
        cmd_valid = 1'b0;
        step();
        chk("t5_pre_penable", PENABLE, 1'b1);
        chk("t5_pre_count", fifo_count, 3'd2);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("t5_psel", PSEL, 1'b0);
        chk("t5_penable", PENABLE, 1'b0);
        chk("t5_fifo_count", fifo_count, 3'd0);
        chk("t5_cmd_ready", cmd_ready, 1'b1);
        chk("t5_busy", busy, 1'b0);
        chk("t5_paddr", PADDR, 32'h0);
        chk("t5_pstrb", PSTRB, 4'h0);
        chk("t5_pwrite", PWRITE, 1'b0);
        chk("t5_rsp_valid", rsp_valid, 1'b0);
        PREADY = 1'b1;
        step();
        step();
        PRESETn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_post_rsp", rsp_valid, 1'b0);
            chk("t5_post_psel", PSEL, 1'b0);
        end

`ifdef APB_MASTER_Q_TIMEOUT_EN
        // Watchdog abort with PREADY stuck low
        PREADY    = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h300;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("t6_access_entry", PENABLE, 1'b1);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("t6_wait_penable", PENABLE, 1'b1);
            chk("t6_wait_no_rsp", rsp_valid, 1'b0);
        end
        step();
        chk("t6_rsp_valid", rsp_valid, 1'b1);
        chk("t6_rsp_err", rsp_err, 1'b1);
        chk("t6_rsp_timeout", rsp_timeout, 1'b1);
        chk("t6_rsp_rdata", rsp_rdata, 32'h0);
        chk("t6_psel_drop", PSEL, 1'b0);
        PREADY = 1'b1;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
